quad_decoder: RTL and testbench

//  Incremental (quadrature) encoder decoder, x4 resolution. Samples the

---
 rtl/quad_decoder_pkg.sv | 30 +++
 rtl/sync_ff.sv | 24 ++
 rtl/quad_decoder.sv | 143 ++++++++++++++
 tb/tb_quad_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared quadrature decode definitions: Gray state codes, decode result codes, decode table.
// Purely combinational helpers; no latency and no backpressure.
package quad_decoder_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_FWD  = 2'd1,
    DEC_REV  = 2'd2,
    DEC_ERR  = 2'd3
  } dec_t;

  // prev/cur are {a,b}; a diagonal jump across the Gray cycle is an error
  function automatic dec_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_t res;
    res = DEC_NONE;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: res = DEC_FWD;
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: res = DEC_REV;
      {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: res = DEC_ERR;
      default:                                        res = DEC_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit.
// Latency STAGES clk cycles; no backpressure.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes A/B, emits step/dir/err pulses, keeps a wrapping position.
// Latency SYNC_STAGES+1 clk edges from input edge to pulse; no backpressure (max one transition per SYNC_STAGES+1 cycles).
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] D,
  output logic         step,
  output logic         dir,
  output logic         err,
  output logic         err_flag,
  output logic         wrap_tick,
  output logic [N-1:0] pos
);

  localparam int PW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } prime_state_t;

  logic         as_s;
  logic         bs_s;
  logic [1:0]   cur;
  logic [1:0]   prev;
  prime_state_t state;
  prime_state_t state_nxt;
  logic [PW-1:0] prime_cnt;
  logic [PW-1:0] prime_cnt_nxt;
  logic         decode_en;
  dec_t         dec;
  logic         is_step;
  logic [N-1:0] pos_nxt;
  logic         wrap_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a),
    .q   (as_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (b),
    .q   (bs_s)
  );

  assign cur = {as_s, bs_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_cnt_nxt;
    end
  end

  // Hold off decode until prev reflects a fully flushed synchronizer pipeline
  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    decode_en     = 1'b0;
    case (state)
      ST_PRIME: begin
        if (prime_cnt == PW'(SYNC_STAGES)) begin
          state_nxt     = ST_RUN;
          prime_cnt_nxt = '0;
        end else begin
          prime_cnt_nxt = prime_cnt + PW'(1);
        end
      end
      ST_RUN: begin
        decode_en = 1'b1;
      end
      default: begin
        state_nxt = ST_PRIME;
      end
    endcase
    if (clr) begin
      state_nxt     = ST_PRIME;
      prime_cnt_nxt = '0;
    end
  end

  assign dec     = decode_en ? quad_decode(prev, cur) : DEC_NONE;
  assign is_step = (dec == DEC_FWD) || (dec == DEC_REV);

  always_comb begin
    pos_nxt  = pos;
    wrap_nxt = 1'b0;
    if (clr) begin
      pos_nxt = '0;
    end else if (load) begin
      pos_nxt = D;
    end else if (dec == DEC_FWD) begin
      pos_nxt  = pos + N'(1);
      wrap_nxt = (pos == {N{1'b1}});
    end else if (dec == DEC_REV) begin
      pos_nxt  = pos - N'(1);
      wrap_nxt = (pos == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      err_flag  <= 1'b0;
      wrap_tick <= 1'b0;
      pos       <= '0;
    end else begin
      prev      <= cur;
      step      <= is_step && !clr;
      err       <= (dec == DEC_ERR) && !clr;
      wrap_tick <= wrap_nxt;
      pos       <= pos_nxt;
      if (is_step && !clr) begin
        dir <= (dec == DEC_FWD);
      end
      if (clr) begin
        err_flag <= 1'b0;
      end else if (dec == DEC_ERR) begin
        err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed + randomized bench for quad_decoder against a Gray-index arithmetic model.
module tb_quad_decoder;

  localparam int N  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         a;
  logic         b;
  logic         clr;
  logic         load;
  logic [N-1:0] D;
  logic         step;
  logic         dir;
  logic         err;
  logic         err_flag;
  logic         wrap_tick;
  logic [N-1:0] pos;

  int tests = 0;
  int fails = 0;

  // Position of each {a,b} code around the quadrature cycle, and its inverse
  int idx_of_ab[4] = '{0, 1, 3, 2};
  logic [1:0] ab_of_idx[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic [1:0] m_ab;
  logic [7:0] m_pos;
  logic       m_dir;
  logic       m_flag;
  int         last_lat;

  quad_decoder #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .clr       (clr),
    .load      (load),
    .D         (D),
    .step      (step),
    .dir       (dir),
    .err       (err),
    .err_flag  (err_flag),
    .wrap_tick (wrap_tick),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [1:0] nv, input int win, input string tag);
    int d;
    int ns;
    int ne;
    int nw;
    int lat;
    int exp_s;
    int exp_e;
    int exp_w;
    ns  = 0;
    ne  = 0;
    nw  = 0;
    lat = -1;
    d     = (idx_of_ab[nv] - idx_of_ab[m_ab] + 4) % 4;
    exp_s = (d == 1 || d == 3) ? 1 : 0;
    exp_e = (d == 2) ? 1 : 0;
    exp_w = ((d == 1 && m_pos == 8'hFF) || (d == 3 && m_pos == 8'h00)) ? 1 : 0;
    if (d == 1) begin
      m_pos = m_pos + 8'd1;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_pos = m_pos - 8'd1;
      m_dir = 1'b0;
    end else if (d == 2) begin
      m_flag = 1'b1;
    end
    m_ab  = nv;
    {a, b} = nv;
    for (int i = 1; i <= win; i++) begin
      tick();
      if (step === 1'b1) begin
        ns++;
        if (lat < 0) lat = i;
      end
      if (err === 1'b1) ne++;
      if (wrap_tick === 1'b1) nw++;
    end
    last_lat = lat;
    chk({tag, "_steps"}, ns, exp_s);
    chk({tag, "_errs"},  ne, exp_e);
    chk({tag, "_wraps"}, nw, exp_w);
    chk({tag, "_pos"},   pos, m_pos);
    chk({tag, "_dir"},   dir, m_dir);
    chk({tag, "_flag"},  err_flag, m_flag);
  endtask

  initial begin
    int quiet;
    int r;
    int ci;
    rst  = 1'b1;
    a    = 1'b0;
    b    = 1'b0;
    clr  = 1'b0;
    load = 1'b0;
    D    = '0;
    m_ab = 2'b00;
    m_pos = 8'h00;
    m_dir = 1'b0;
    m_flag = 1'b0;
    last_lat = -1;
    repeat (3) tick();
    chk("rst_pos", pos, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_wrap", wrap_tick, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Four forward steps; first one also measures latency
    move(2'b01, 8, "fwd1");
    chk("latency", last_lat, SS + 1);
    move(2'b11, 8, "fwd2");
    move(2'b10, 8, "fwd3");
    move(2'b00, 8, "fwd4");
    chk("fwd_pos4", pos, 4);

    // Wrap both directions from a loaded maximum
    D = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    m_pos = 8'hFF;
    chk("load_pos", pos, 8'hFF);
    chk("load_nowrap", wrap_tick, 0);
    move(2'b01, 8, "wrap_up");
    move(2'b00, 8, "wrap_dn");

    // Illegal diagonal, then clear
    move(2'b11, 8, "illegal");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_pos = 8'h00;
    m_flag = 1'b0;
    chk("clr_pos", pos, 0);
    chk("clr_flag", err_flag, 0);
    chk("clr_step", step, 0);
    repeat (4) tick();

    // Async reset mid-operation, release with inputs at 11
    move(2'b10, 8, "pre_rst");
    rst = 1'b1;
    {a, b} = 2'b11;
    #1;
    chk("async_pos", pos, 0);
    chk("async_dir", dir, 0);
    repeat (2) tick();
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step !== 1'b0 || err !== 1'b0) quiet++;
    end
    chk("prime_quiet", quiet, 0);
    chk("prime_pos", pos, 0);
    m_ab = 2'b11;
    m_pos = 8'h00;
    m_dir = 1'b0;
    m_flag = 1'b0;

    // Load in the same cycle a forward step reaches decode
    {a, b} = 2'b10;
    tick();
    tick();
    D = 8'h10;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ldstep_step", step, 1);
    chk("ldstep_pos", pos, 8'h10);
    chk("ldstep_dir", dir, 1);
    tick();
    chk("ldstep_pos2", pos, 8'h10);
    m_ab = 2'b10;
    m_pos = 8'h10;
    m_dir = 1'b1;

    // Clear in the same cycle a step reaches decode
    {a, b} = 2'b00;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrstep_step", step, 0);
    chk("clrstep_pos", pos, 0);
    chk("clrstep_wrap", wrap_tick, 0);
    m_ab = 2'b00;
    m_pos = 8'h00;
    repeat (4) tick();
    chk("clrstep_after", pos, 0);

    // Random walk with occasional errors, idles and loads
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 9) begin
        D = 8'($urandom);
        load = 1'b1;
        tick();
        load = 1'b0;
        m_pos = D;
        chk("rnd_load", pos, m_pos);
      end
      r  = int'($urandom_range(0, 19));
      ci = idx_of_ab[m_ab];
      if (r < 8)       move(ab_of_idx[(ci + 1) % 4], int'($urandom_range(4, 8)), "rnd_f");
      else if (r < 16) move(ab_of_idx[(ci + 3) % 4], int'($urandom_range(4, 8)), "rnd_r");
      else if (r < 18) move(m_ab, int'($urandom_range(4, 8)), "rnd_n");
      else             move(ab_of_idx[(ci + 2) % 4], int'($urandom_range(4, 8)), "rnd_e");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
